// File: rtl/receptor_pkg.sv
// rtl/receptor_pkg.sv - shared state encoding, parity modes and parity helper for the UART receiver
package receptor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Parity bit a correct transmitter would send for this word (unused upper bits must be zero)
    function automatic logic expected_parity(input logic [8:0] word, input int mode);
        return (^word) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/receptor_uart_tick_gen.sv
// rtl/receptor_uart_tick_gen.sv - oversample tick divider with synchronous phase clear
module rx_tick_gen #(
    parameter int CLK_DIV = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int                DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Free-running divider; a clear realigns the phase to the detected start edge
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == DIV_LAST)) begin
            cnt_d = '0;
        end
    end

    assign tick = (cnt_q == DIV_LAST) && !clr;

    // Divider state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/receptor_uart.sv
// rtl/receptor_uart.sv - oversampling asynchronous serial receiver with voting, parity and break handling
module receptor_uart
    import receptor_pkg::*;
#(
    parameter int CLK_DIV    = 27,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 x,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int               K_W    = $clog2(OVERSAMPLE);
    localparam int               M      = OVERSAMPLE / 2;
    localparam logic [K_W-1:0]   K_PRE  = K_W'(M - 1);
    localparam logic [K_W-1:0]   K_MID  = K_W'(M);
    localparam logic [K_W-1:0]   K_POST = K_W'(M + 1);
    localparam logic [K_W-1:0]   K_LAST = K_W'(OVERSAMPLE - 1);
    localparam int               NBITS  = DATA_BITS + ((PARITY != PAR_NONE) ? 1 : 0) + STOP_BITS;
    localparam int               B_W    = $clog2(NBITS + 1);
    localparam logic [B_W-1:0]   B_LAST_DATA = B_W'(DATA_BITS - 1);
    localparam logic [B_W-1:0]   B_LAST      = B_W'(NBITS - 1);

    logic x_meta_q, xs_q, xs_prev_q;
    logic tick, fall, vote, ferr_now, at_post, bit_end, clr;

    rx_state_e            state_q, state_d;
    logic [K_W-1:0]       k_q, k_d;
    logic [B_W-1:0]       bit_q, bit_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_acc_q, perr_acc_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;

    // Two-stage synchroniser plus one delayed copy for falling-edge detection; idles high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_meta_q  <= 1'b1;
            xs_q      <= 1'b1;
            xs_prev_q <= 1'b1;
        end else begin
            x_meta_q  <= x;
            xs_q      <= x_meta_q;
            xs_prev_q <= xs_q;
        end
    end

    assign fall     = xs_prev_q && !xs_q;
    assign clr      = (state_q == ST_IDLE) && fall;
    assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & xs_q) | (samp_q[1] & xs_q);
    assign ferr_now = ferr_acc_q | ~vote;
    assign at_post  = tick && (k_q == K_POST);
    assign bit_end  = tick && (k_q == K_LAST);

    rx_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .tick  (tick)
    );

    // Frame FSM: bit-phase counting, vote sampling, shifting, error accumulation and commit
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        bit_d        = bit_q;
        samp_d       = samp_q;
        shift_d      = shift_q;
        perr_acc_d   = perr_acc_q;
        ferr_acc_d   = ferr_acc_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        if (tick) begin
            k_d = (k_q == K_LAST) ? '0 : k_q + 1'b1;
            if (k_q == K_PRE) samp_d[0] = xs_q;
            if (k_q == K_MID) samp_d[1] = xs_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d    = ST_START;
                    k_d        = '0;
                    bit_d      = '0;
                    perr_acc_d = 1'b0;
                    ferr_acc_d = 1'b0;
                end
            end
            ST_START: begin
                if (at_post && vote) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (at_post) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                end
                if (bit_end) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == B_LAST_DATA) begin
                        state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    end
                end
            end
            ST_PAR: begin
                if (at_post && (vote != expected_parity(9'(shift_q), PARITY))) begin
                    perr_acc_d = 1'b1;
                end
                if (bit_end) begin
                    bit_d   = bit_q + 1'b1;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (at_post) begin
                    ferr_acc_d = ferr_now;
                    if (bit_q == B_LAST) begin
                        // Commit at mid-stop so an immediately following start edge is not missed
                        data_d       = shift_q;
                        parity_err_d = perr_acc_q;
                        frame_err_d  = ferr_now;
                        valid_d      = 1'b1;
                        state_d      = (ferr_now && (shift_q == '0)) ? ST_BREAK : ST_IDLE;
                    end
                end else if (bit_end) begin
                    bit_d = bit_q + 1'b1;
                end
            end
            ST_BREAK: begin
                if (xs_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            bit_q        <= '0;
            samp_q       <= '0;
            shift_q      <= '0;
            perr_acc_q   <= 1'b0;
            ferr_acc_q   <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            bit_q        <= bit_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            perr_acc_q   <= perr_acc_d;
            ferr_acc_q   <= ferr_acc_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/receptor_uart.md
# receptor_uart

Parametrised asynchronous serial receiver that recovers frames from line `x` and presents each one as a parallel word with a one-cycle `valid` strobe. It generalises the fixed 8N1 receiver: configurable word length, parity, stop bits and oversampling, plus majority-vote sampling, false-start rejection, error flags and break handling. Everything runs on the single system clock `clk` using an internal oversample tick enable, with no derived clocks. It sits between the board serial pin and the command/byte consumers.

## Interface
- `CLK_DIV`, 27: `clk` cycles per oversample tick (≥2).
- `OVERSAMPLE`, 16: ticks per bit; even, 8..32.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `x` input 1: serial line, idle high, asynchronous to `clk`.
- `data` output DATA_BITS: last received word, LSB first on line.
- `valid` output 1: one-cycle pulse, new `data`/flags.
- `parity_err` output 1: parity mismatch for current `data`.
- `frame_err` output 1: a stop bit sampled low for current `data`.
- `busy` output 1: high whenever state ≠ IDLE.

## Operation
- `x` passes through a 2-FF synchroniser. All decisions use the synchronised value `xs`.
- Tick generator: counter 0..CLK_DIV-1, `tick` high one `clk` when it wraps. It is forced to 0 on start-edge detection so bit phase aligns to the edge.
- Per-bit tick counter `k` runs 0..OVERSAMPLE-1. Mid point is M = OVERSAMPLE/2.
- Bit value is the majority of `xs` at ticks M-1, M and M+1.
- States are IDLE, START, DATA, PAR, STOP, BREAK.
- IDLE: on `xs` 1→0, go to START and clear the counters.
- START: at k = M+1, a majority of 1 is a false start and returns to IDLE with no `valid`. Otherwise continue and go to DATA at the end of the bit.
- DATA: shift the voted bit in LSB first. After DATA_BITS bits, go to PAR if PARITY ≠ 0, else to STOP.
- PAR: the voted bit is compared with the XOR of the data bits (even), or its inverse (odd). A mismatch sets the internal parity error.
- STOP: vote each stop bit; any 0 sets the internal frame error.
  - At the mid-sample of the last stop bit, the FSM commits `data`, `parity_err` and `frame_err` and pulses `valid`.
  - It then goes to IDLE immediately, not at bit end, so the next start edge is caught early.
- BREAK: entered instead of IDLE when the frame error is set and data is all zeros. `valid` is still pulsed once with `frame_err` = 1. The FSM stays in BREAK until `xs` = 1, then returns to IDLE with no further `valid`.
- `data`, `parity_err` and `frame_err` hold until the next commit. Error flags are never sticky across frames.

## Timing
- Reset values: `data` = 0, `valid` = 0, `parity_err` = 0, `frame_err` = 0, `busy` = 0, FSM = IDLE, synchroniser = 1.
- `busy` rises 3 `clk` cycles after `x` falls: 2 synchroniser cycles plus 1 edge-detect register.
- `valid` rises on the `clk` edge after the M+1 tick of the last stop bit. From start edge this is about ((1 + DATA_BITS + (PARITY≠0) + STOP_BITS − 1)·OVERSAMPLE + M + 1)·CLK_DIV + 3 cycles.
- `valid` is exactly one cycle wide. There is no back-pressure; the consumer must latch within one frame time.
- `reset` asserted at any point aborts the frame immediately with no `valid`. Reception resumes on the first falling edge after `reset` deasserts.
- Width rules:
  - `k` is $clog2(OVERSAMPLE) bits; the divider is $clog2(CLK_DIV) bits.
  - A bit counter counts DATA_BITS + parity + stop bits.
  - No counter may overflow for legal parameters.

## Structure
- Package `receptor_pkg` holds the state enum, the parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD, and a function computing the expected parity.
- One sub-module, `rx_tick_gen` (CLK_DIV divider with sync clear, `tick` output). The FSM, voter and shifter stay in `receptor_uart`.

## Test plan
- 8N1, CLK_DIV = 4, OVERSAMPLE = 16, send 0x55 → one `valid`, `data` = 0x55, both errors 0, `busy` back to 0.
- 8E1, send 0xA3 with parity bit = 1 (correct value 0) → `data` = 0xA3, `parity_err` = 1, `frame_err` = 0. The next frame, 0x3C with correct parity, clears `parity_err`.
- 8N2, send 0x0F with second stop bit low → `frame_err` = 1, `data` = 0x0F.
- Low glitch of 3 ticks on idle line → `busy` pulses, no `valid`, FSM in IDLE. A 1-tick glitch inside a data bit is outvoted, so 0xFF is still received.
- Line low for 20 bit times → exactly one `valid` with `data` = 0x00 and `frame_err` = 1. No further `valid` until the line goes high, then 0x41 is received cleanly.
- `reset` pulse mid-byte → all outputs 0, no `valid`. Back-to-back frames 0x12, 0x34 with no idle gap → two `valid` pulses with correct data.
